// File: rtl/flit_sink_monitor_pkg.sv
// Shared definitions for the flit sink monitor: flit type codes, type-field
// placement, FSM encodings and default widths.
package flit_sink_monitor_pkg;

  localparam int DATAW_DEF = 66;
  localparam int VCHW_DEF  = 2;
  localparam int LENW_DEF  = 8;
  localparam int CNTW_DEF  = 32;
  localparam int TYPEW     = 2;

  typedef enum logic [1:0] {
    TYPE_NONE = 2'b00,
    TYPE_HEAD = 2'b01,
    TYPE_DATA = 2'b10,
    TYPE_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } state_e;

  // The type field occupies the top TYPEW bits of a flit.
  function automatic int type_lsb(input int dataw);
    return dataw - TYPEW;
  endfunction

endpackage

// File: rtl/flit_sink_monitor_popcount_tree.sv
// Combinational popcount of a W-bit vector built as a balanced adder tree
// over a power-of-two padded set of leaves.
module popcount_tree
  import flit_sink_monitor_pkg::*;
#(
  parameter int W = DATAW_DEF
) (
  input  logic [W-1:0]             i_vec,
  output logic [$clog2(W+1)-1:0]   o_cnt
);

  localparam int OUTW   = $clog2(W + 1);
  localparam int LVLS   = $clog2(W);
  localparam int LEAVES = 1 << LVLS;

  logic [OUTW-1:0] w_node [0:LVLS][0:LEAVES-1];

  // Leaves hold one input bit each; every level sums adjacent pairs.
  always_comb begin
    for (int l = 0; l <= LVLS; l++) begin
      for (int n = 0; n < LEAVES; n++) begin
        w_node[l][n] = {OUTW{1'b0}};
      end
    end
    for (int i = 0; i < W; i++) begin
      w_node[0][i] = OUTW'(i_vec[i]);
    end
    for (int l = 0; l < LVLS; l++) begin
      for (int n = 0; n < (LEAVES >> (l + 1)); n++) begin
        w_node[l+1][n] = w_node[l][2*n] + w_node[l][2*n+1];
      end
    end
  end

  assign o_cnt = w_node[LVLS][0];

endmodule

// File: rtl/flit_sink_monitor.sv
// Flit stream sink: checks HEAD/DATA*/TAIL framing, reports completed packets
// and accumulates data-bus toggle activity inside a measurement window.
module flit_sink_monitor
  import flit_sink_monitor_pkg::*;
#(
  parameter int DATAW = DATAW_DEF,
  parameter int VCHW  = VCHW_DEF,
  parameter int LENW  = LENW_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [DATAW-1:0] idata,
  input  logic             ivalid,
  input  logic [VCHW-1:0]  ivch,
  input  logic             meas_en,
  input  logic             clr,
  output logic             pkt_done,
  output logic [LENW-1:0]  pkt_len,
  output logic [VCHW-1:0]  pkt_vch,
  output logic [CNTW-1:0]  pkt_cnt,
  output logic [CNTW-1:0]  toggle_cnt,
  output logic [CNTW-1:0]  err_cnt,
  output logic             err_flag
);

  localparam int TYPE_LSB = type_lsb(DATAW);
  localparam int POPW     = $clog2(DATAW + 1);

  flit_type_e       w_type;
  state_e           r_state;
  state_e           w_state_nxt;
  logic [LENW-1:0]  r_len;
  logic [LENW-1:0]  w_len_nxt;
  logic [LENW-1:0]  w_len_inc;
  logic [VCHW-1:0]  r_cur_vch;
  logic [VCHW-1:0]  w_cur_vch_nxt;
  logic             w_err;
  logic             w_done;

  logic             r_pkt_done;
  logic [LENW-1:0]  r_pkt_len;
  logic [VCHW-1:0]  r_pkt_vch;
  logic [CNTW-1:0]  r_pkt_cnt;
  logic [CNTW-1:0]  r_toggle_cnt;
  logic [CNTW-1:0]  r_err_cnt;
  logic             r_err_flag;
  logic [DATAW-1:0] r_prev_data;
  logic             r_prev_ok;

  logic [POPW-1:0]  w_pop;
  logic [CNTW:0]    w_tog_sum;

  assign w_type    = flit_type_e'(idata[TYPE_LSB +: TYPEW]);
  assign w_len_inc = (r_len == {LENW{1'b1}}) ? r_len : r_len + LENW'(1'b1);

  popcount_tree #(
    .W (DATAW)
  ) u_popcount (
    .i_vec (idata ^ r_prev_data),
    .o_cnt (w_pop)
  );

  assign w_tog_sum = {1'b0, r_toggle_cnt} + (CNTW + 1)'(w_pop);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state   <= ST_IDLE;
      r_len     <= {LENW{1'b0}};
      r_cur_vch <= {VCHW{1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_len     <= w_len_nxt;
      r_cur_vch <= w_cur_vch_nxt;
    end
  end

  // NONE flits never affect framing, including the VC consistency check.
  always_comb begin
    w_state_nxt   = r_state;
    w_len_nxt     = r_len;
    w_cur_vch_nxt = r_cur_vch;
    w_err         = 1'b0;
    w_done        = 1'b0;
    if (ivalid) begin
      case (r_state)
        ST_IDLE: begin
          case (w_type)
            TYPE_HEAD: begin
              w_state_nxt   = ST_BODY;
              w_len_nxt     = LENW'(1'b1);
              w_cur_vch_nxt = ivch;
            end
            TYPE_DATA, TYPE_TAIL: w_err = 1'b1;
            default:              w_err = 1'b0;
          endcase
        end
        ST_BODY: begin
          if ((w_type != TYPE_NONE) && (ivch != r_cur_vch)) begin
            w_err = 1'b1;
          end else begin
            w_err = 1'b0;
          end
          case (w_type)
            TYPE_HEAD: begin
              w_err         = 1'b1;
              w_len_nxt     = LENW'(1'b1);
              w_cur_vch_nxt = ivch;
            end
            TYPE_DATA: w_len_nxt = w_len_inc;
            TYPE_TAIL: begin
              w_state_nxt = ST_IDLE;
              w_done      = 1'b1;
            end
            default: w_state_nxt = ST_BODY;
          endcase
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_pkt_done <= 1'b0;
      r_pkt_len  <= {LENW{1'b0}};
      r_pkt_vch  <= {VCHW{1'b0}};
    end else begin
      r_pkt_done <= w_done;
      if (w_done) begin
        r_pkt_len <= w_len_inc;
        r_pkt_vch <= r_cur_vch;
      end else begin
        r_pkt_len <= r_pkt_len;
        r_pkt_vch <= r_pkt_vch;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_prev_data <= {DATAW{1'b0}};
      r_prev_ok   <= 1'b0;
    end else begin
      if (ivalid) begin
        r_prev_data <= idata;
      end else begin
        r_prev_data <= r_prev_data;
      end
      if (clr) begin
        r_prev_ok <= 1'b0;
      end else if (ivalid) begin
        r_prev_ok <= 1'b1;
      end else begin
        r_prev_ok <= r_prev_ok;
      end
    end
  end

  // Measurement counters: clr wins, all saturate instead of wrapping.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_pkt_cnt    <= {CNTW{1'b0}};
      r_toggle_cnt <= {CNTW{1'b0}};
      r_err_cnt    <= {CNTW{1'b0}};
      r_err_flag   <= 1'b0;
    end else if (clr) begin
      r_pkt_cnt    <= {CNTW{1'b0}};
      r_toggle_cnt <= {CNTW{1'b0}};
      r_err_cnt    <= {CNTW{1'b0}};
      r_err_flag   <= 1'b0;
    end else if (meas_en) begin
      if (w_done && (r_pkt_cnt != {CNTW{1'b1}})) begin
        r_pkt_cnt <= r_pkt_cnt + CNTW'(1'b1);
      end else begin
        r_pkt_cnt <= r_pkt_cnt;
      end
      if (ivalid && r_prev_ok) begin
        r_toggle_cnt <= w_tog_sum[CNTW] ? {CNTW{1'b1}} : w_tog_sum[CNTW-1:0];
      end else begin
        r_toggle_cnt <= r_toggle_cnt;
      end
      if (w_err && (r_err_cnt != {CNTW{1'b1}})) begin
        r_err_cnt <= r_err_cnt + CNTW'(1'b1);
      end else begin
        r_err_cnt <= r_err_cnt;
      end
      r_err_flag <= r_err_flag | w_err;
    end else begin
      r_pkt_cnt    <= r_pkt_cnt;
      r_toggle_cnt <= r_toggle_cnt;
      r_err_cnt    <= r_err_cnt;
      r_err_flag   <= r_err_flag;
    end
  end

  assign pkt_done   = r_pkt_done;
  assign pkt_len    = r_pkt_len;
  assign pkt_vch    = r_pkt_vch;
  assign pkt_cnt    = r_pkt_cnt;
  assign toggle_cnt = r_toggle_cnt;
  assign err_cnt    = r_err_cnt;
  assign err_flag   = r_err_flag;

endmodule

// File: tb/tb_flit_sink_monitor.sv
// Directed bench for flit_sink_monitor: framing, packet reporting, toggle
// accounting, measurement window, clear and asynchronous reset.
module tb_flit_sink_monitor;

  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_DATA = 2'b10;
  localparam logic [1:0] T_TAIL = 2'b11;

  logic        clk = 1'b0;
  logic        rst_;
  logic [65:0] idata;
  logic        ivalid;
  logic [1:0]  ivch;
  logic        meas_en;
  logic        clr;
  logic        pkt_done;
  logic [7:0]  pkt_len;
  logic [1:0]  pkt_vch;
  logic [31:0] pkt_cnt;
  logic [31:0] toggle_cnt;
  logic [31:0] err_cnt;
  logic        err_flag;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          pulses = 0;
  logic [65:0] tb_prev;
  logic        tb_prev_ok;
  logic [31:0] exp_toggle;

  flit_sink_monitor dut (
    .clk        (clk),
    .rst_       (rst_),
    .idata      (idata),
    .ivalid     (ivalid),
    .ivch       (ivch),
    .meas_en    (meas_en),
    .clr        (clr),
    .pkt_done   (pkt_done),
    .pkt_len    (pkt_len),
    .pkt_vch    (pkt_vch),
    .pkt_cnt    (pkt_cnt),
    .toggle_cnt (toggle_cnt),
    .err_cnt    (err_cnt),
    .err_flag   (err_flag)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pkt_done === 1'b1) pulses <= pulses + 1;
  end

  function automatic logic [63:0] fill(input int k);
    logic [63:0] ones;
    ones = '1;
    if (k >= 32) return ones;
    return (64'd1 << (2 * k)) - 64'd1;
  endfunction

  function automatic logic [63:0] drain(input int k);
    logic [63:0] ones;
    ones = '1;
    if (k >= 32) return 64'd0;
    return ones << (2 * k);
  endfunction

  task automatic send(input logic [1:0] t, input logic [63:0] p,
                      input logic [1:0] v, input logic c);
    logic [65:0] f;
    f = {t, p};
    @(negedge clk);
    idata = f; ivalid = 1'b1; ivch = v; clr = c;
    if (c) begin
      exp_toggle = 32'd0;
      tb_prev_ok = 1'b0;
    end else begin
      if (tb_prev_ok && meas_en) exp_toggle = exp_toggle + 32'($countones(f ^ tb_prev));
      tb_prev_ok = 1'b1;
    end
    tb_prev = f;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ivalid = 1'b0; clr = 1'b0;
    end
  endtask

  task automatic do_clr();
    @(negedge clk);
    ivalid = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_toggle = 32'd0;
    tb_prev_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_ = 1'b0; idata = 66'd0; ivalid = 1'b0; ivch = 2'd0; meas_en = 1'b1; clr = 1'b0;
    tb_prev = 66'd0; tb_prev_ok = 1'b0; exp_toggle = 32'd0;
    repeat (3) @(negedge clk);
    n_chk++; if (pkt_done !== 1'b0) $display("FAIL rst_done: got %0b exp 0", pkt_done); else n_pass++;
    n_chk++; if (pkt_len !== 8'd0) $display("FAIL rst_len: got %0d exp 0", pkt_len); else n_pass++;
    n_chk++; if (pkt_vch !== 2'd0) $display("FAIL rst_vch: got %0d exp 0", pkt_vch); else n_pass++;
    n_chk++; if (pkt_cnt !== 32'd0) $display("FAIL rst_pkt_cnt: got %0d exp 0", pkt_cnt); else n_pass++;
    n_chk++; if (toggle_cnt !== 32'd0) $display("FAIL rst_toggle: got %0d exp 0", toggle_cnt); else n_pass++;
    n_chk++; if (err_cnt !== 32'd0) $display("FAIL rst_err_cnt: got %0d exp 0", err_cnt); else n_pass++;
    n_chk++; if (err_flag !== 1'b0) $display("FAIL rst_err_flag: got %0b exp 0", err_flag); else n_pass++;
    rst_ = 1'b1;
    // first valid flit adds nothing; the next NONE flit flips 64 payload bits
    send(T_NONE, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 1'b0);
    idle(2);
    n_chk++; if (toggle_cnt !== 32'd0) $display("FAIL first_flit_toggle: got %0d exp 0", toggle_cnt); else n_pass++;
    send(T_NONE, 64'd0, 2'd0, 1'b0);
    idle(2);
    n_chk++; if (toggle_cnt !== 32'd64) $display("FAIL none_toggle: got %0d exp 64", toggle_cnt); else n_pass++;
    n_chk++; if (err_cnt !== 32'd0) $display("FAIL none_err: got %0d exp 0", err_cnt); else n_pass++;
  endtask

  task automatic test_long_packet();
    int p0;
    do_clr();
    p0 = pulses;
    send(T_HEAD, 64'd0, 2'd1, 1'b0);
    for (int k = 1; k <= 20; k++) send(T_DATA, fill(k), 2'd1, 1'b0);
    send(T_TAIL, 64'd0, 2'd1, 1'b0);
    idle(2);
    n_chk++; if (pulses - p0 !== 1) $display("FAIL long_pulses: got %0d exp 1", pulses - p0); else n_pass++;
    n_chk++; if (pkt_len !== 8'd22) $display("FAIL long_len: got %0d exp 22", pkt_len); else n_pass++;
    n_chk++; if (pkt_vch !== 2'd1) $display("FAIL long_vch: got %0d exp 1", pkt_vch); else n_pass++;
    n_chk++; if (pkt_cnt !== 32'd1) $display("FAIL long_pkt_cnt: got %0d exp 1", pkt_cnt); else n_pass++;
    n_chk++; if (err_cnt !== 32'd0) $display("FAIL long_err: got %0d exp 0", err_cnt); else n_pass++;
    n_chk++; if (toggle_cnt !== exp_toggle) $display("FAIL long_toggle: got %0d exp %0d", toggle_cnt, exp_toggle); else n_pass++;
  endtask

  task automatic test_toggle_fill();
    idle(7);
    send(T_HEAD, 64'd0, 2'd2, 1'b0);
    for (int k = 1; k <= 32; k++) send(T_DATA, fill(k), 2'd2, 1'b0);
    for (int k = 1; k <= 32; k++) send(T_DATA, drain(k), 2'd2, 1'b0);
    send(T_TAIL, 64'd0, 2'd2, 1'b0);
    idle(7);
    n_chk++; if (toggle_cnt !== exp_toggle) $display("FAIL fill_toggle: got %0d exp %0d", toggle_cnt, exp_toggle); else n_pass++;
    n_chk++; if (pkt_len !== 8'd66) $display("FAIL fill_len: got %0d exp 66", pkt_len); else n_pass++;
    n_chk++; if (pkt_cnt !== 32'd2) $display("FAIL fill_pkt_cnt: got %0d exp 2", pkt_cnt); else n_pass++;
  endtask

  task automatic test_errors();
    int p0;
    do_clr();
    p0 = pulses;
    send(T_TAIL, 64'd5, 2'd0, 1'b0);
    send(T_HEAD, 64'd6, 2'd0, 1'b0);
    send(T_HEAD, 64'd7, 2'd0, 1'b0);
    send(T_TAIL, 64'd8, 2'd0, 1'b0);
    idle(2);
    n_chk++; if (err_cnt !== 32'd2) $display("FAIL err_cnt2: got %0d exp 2", err_cnt); else n_pass++;
    n_chk++; if (err_flag !== 1'b1) $display("FAIL err_flag: got %0b exp 1", err_flag); else n_pass++;
    n_chk++; if (pkt_len !== 8'd2) $display("FAIL err_len: got %0d exp 2", pkt_len); else n_pass++;
    n_chk++; if (pulses - p0 !== 1) $display("FAIL err_pulses: got %0d exp 1", pulses - p0); else n_pass++;
    // HEAD inside a packet on a new VC is two faults in one cycle: one count
    send(T_HEAD, 64'd0, 2'd0, 1'b0);
    send(T_HEAD, 64'd0, 2'd2, 1'b0);
    send(T_TAIL, 64'd0, 2'd2, 1'b0);
    idle(2);
    n_chk++; if (err_cnt !== 32'd3) $display("FAIL err_one_per_cycle: got %0d exp 3", err_cnt); else n_pass++;
    n_chk++; if (pkt_vch !== 2'd2) $display("FAIL err_restart_vch: got %0d exp 2", pkt_vch); else n_pass++;
    n_chk++; if (pkt_cnt !== 32'd2) $display("FAIL err_pkt_cnt: got %0d exp 2", pkt_cnt); else n_pass++;
  endtask

  task automatic test_vch_change();
    do_clr();
    send(T_HEAD, 64'd1, 2'd0, 1'b0);
    send(T_DATA, 64'd2, 2'd0, 1'b0);
    send(T_DATA, 64'd3, 2'd2, 1'b0);
    send(T_DATA, 64'd4, 2'd0, 1'b0);
    send(T_TAIL, 64'd5, 2'd0, 1'b0);
    idle(2);
    n_chk++; if (err_cnt !== 32'd1) $display("FAIL vch_err: got %0d exp 1", err_cnt); else n_pass++;
    n_chk++; if (pkt_vch !== 2'd0) $display("FAIL vch_pkt_vch: got %0d exp 0", pkt_vch); else n_pass++;
    n_chk++; if (pkt_len !== 8'd5) $display("FAIL vch_len: got %0d exp 5", pkt_len); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int p0;
    do_clr();
    p0 = pulses;
    send(T_HEAD, 64'd0, 2'd0, 1'b0);
    send(T_TAIL, 64'd0, 2'd0, 1'b0);
    send(T_HEAD, 64'd0, 2'd1, 1'b0);
    send(T_TAIL, 64'd0, 2'd1, 1'b0);
    idle(2);
    n_chk++; if (pulses - p0 !== 2) $display("FAIL b2b_pulses: got %0d exp 2", pulses - p0); else n_pass++;
    n_chk++; if (pkt_cnt !== 32'd2) $display("FAIL b2b_pkt_cnt: got %0d exp 2", pkt_cnt); else n_pass++;
    n_chk++; if (err_cnt !== 32'd0) $display("FAIL b2b_err: got %0d exp 0", err_cnt); else n_pass++;
    n_chk++; if (pkt_len !== 8'd2) $display("FAIL b2b_len: got %0d exp 2", pkt_len); else n_pass++;
  endtask

  task automatic test_len_sat();
    send(T_HEAD, 64'd0, 2'd3, 1'b0);
    for (int k = 0; k < 300; k++) send(T_DATA, 64'(k), 2'd3, 1'b0);
    send(T_TAIL, 64'd0, 2'd3, 1'b0);
    idle(2);
    n_chk++; if (pkt_len !== 8'd255) $display("FAIL len_sat: got %0d exp 255", pkt_len); else n_pass++;
    n_chk++; if (toggle_cnt !== exp_toggle) $display("FAIL sat_toggle: got %0d exp %0d", toggle_cnt, exp_toggle); else n_pass++;
  endtask

  task automatic test_meas_clr();
    int p0;
    do_clr();
    p0 = pulses;
    meas_en = 1'b0;
    send(T_HEAD, 64'hA, 2'd1, 1'b0);
    send(T_DATA, 64'h5, 2'd1, 1'b0);
    send(T_TAIL, 64'hF0, 2'd1, 1'b0);
    idle(2);
    meas_en = 1'b1;
    send(T_HEAD, 64'h3, 2'd1, 1'b0);
    send(T_DATA, 64'hC, 2'd1, 1'b0);
    send(T_DATA, 64'hFF, 2'd1, 1'b0);
    send(T_TAIL, 64'h0, 2'd1, 1'b0);
    idle(2);
    n_chk++; if (pkt_cnt !== 32'd1) $display("FAIL meas_pkt_cnt: got %0d exp 1", pkt_cnt); else n_pass++;
    n_chk++; if (pulses - p0 !== 2) $display("FAIL meas_pulses: got %0d exp 2", pulses - p0); else n_pass++;
    n_chk++; if (toggle_cnt !== exp_toggle) $display("FAIL meas_toggle: got %0d exp %0d", toggle_cnt, exp_toggle); else n_pass++;
    p0 = pulses;
    send(T_HEAD, 64'h1, 2'd0, 1'b0);
    send(T_DATA, 64'h2, 2'd0, 1'b0);
    send(T_TAIL, 64'h3, 2'd0, 1'b1);
    idle(2);
    n_chk++; if (pkt_cnt !== 32'd0) $display("FAIL clr_pkt_cnt: got %0d exp 0", pkt_cnt); else n_pass++;
    n_chk++; if (toggle_cnt !== 32'd0) $display("FAIL clr_toggle: got %0d exp 0", toggle_cnt); else n_pass++;
    n_chk++; if (pulses - p0 !== 1) $display("FAIL clr_pulses: got %0d exp 1", pulses - p0); else n_pass++;
    n_chk++; if (pkt_len !== 8'd3) $display("FAIL clr_len: got %0d exp 3", pkt_len); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int p0;
    send(T_HEAD, 64'h11, 2'd1, 1'b0);
    send(T_TAIL, 64'h22, 2'd1, 1'b0);
    send(T_HEAD, 64'h33, 2'd2, 1'b0);
    send(T_DATA, 64'h44, 2'd2, 1'b0);
    send(T_DATA, 64'h55, 2'd2, 1'b0);
    #3;
    rst_ = 1'b0; ivalid = 1'b0;
    #1;
    n_chk++; if (pkt_cnt !== 32'd0) $display("FAIL arst_pkt_cnt: got %0d exp 0", pkt_cnt); else n_pass++;
    n_chk++; if (pkt_len !== 8'd0) $display("FAIL arst_len: got %0d exp 0", pkt_len); else n_pass++;
    n_chk++; if (pkt_vch !== 2'd0) $display("FAIL arst_vch: got %0d exp 0", pkt_vch); else n_pass++;
    n_chk++; if (toggle_cnt !== 32'd0) $display("FAIL arst_toggle: got %0d exp 0", toggle_cnt); else n_pass++;
    n_chk++; if (pkt_done !== 1'b0) $display("FAIL arst_done: got %0b exp 0", pkt_done); else n_pass++;
    tb_prev = 66'd0; tb_prev_ok = 1'b0; exp_toggle = 32'd0;
    @(negedge clk);
    @(negedge clk);
    rst_ = 1'b1;
    p0 = pulses;
    send(T_HEAD, 64'h1, 2'd3, 1'b0);
    send(T_DATA, 64'h3, 2'd3, 1'b0);
    send(T_DATA, 64'h7, 2'd3, 1'b0);
    send(T_TAIL, 64'hF, 2'd3, 1'b0);
    idle(2);
    n_chk++; if (pulses - p0 !== 1) $display("FAIL post_rst_pulses: got %0d exp 1", pulses - p0); else n_pass++;
    n_chk++; if (pkt_len !== 8'd4) $display("FAIL post_rst_len: got %0d exp 4", pkt_len); else n_pass++;
    n_chk++; if (pkt_vch !== 2'd3) $display("FAIL post_rst_vch: got %0d exp 3", pkt_vch); else n_pass++;
    n_chk++; if (pkt_cnt !== 32'd1) $display("FAIL post_rst_pkt_cnt: got %0d exp 1", pkt_cnt); else n_pass++;
    n_chk++; if (err_cnt !== 32'd0) $display("FAIL post_rst_err: got %0d exp 0", err_cnt); else n_pass++;
    n_chk++; if (toggle_cnt !== exp_toggle) $display("FAIL post_rst_toggle: got %0d exp %0d", toggle_cnt, exp_toggle); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_long_packet();
    test_toggle_fill();
    test_errors();
    test_vch_change();
    test_back_to_back();
    test_len_sat();
    test_meas_clr();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
